pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//   Sequences a GTP_PLL_E3-based PLL wrapper: drives its reset, qualifies LOCK and holds the downstream reset until lock is stable.
//   On lock loss or an explicit relock request it resets the PLL and retries, counting failed attempts and lock losses.
//   Sits between the free-running board clock domain and the system/DDR/HDMI reset tree.
// PARAMETERS
//   RST_CYCLES     64     cycles pll_rst is held high per attempt (>=2)
//   LOCK_TIMEOUT   50000  cycles allowed from pll_rst release to first qualified lock (1 ms @ 50 MHz)
//   STABLE_CYCLES  1024   cycles lock must stay continuously high before rst_out releases
//   MAX_RETRY      8      consecutive failed attempts before fail is raised
//   CNT_W          8      width of retry_cnt / loss_cnt
// PORTS
//   clk            in   1      free-running PLL reference clock (same as PLL clkin1)
//   rst            in   1      asynchronous, active-high reset
//   pll_lock       in   1      PLL LOCK, asynchronous to clk
//   relock_req     in   1      single-cycle request to force a full PLL reset/relock
//   pll_rst        out  1      to PLL RST, active high
//   rst_out        out  1      downstream reset, active high
//   locked_stable  out  1      high only in RUN
//   fail           out  1      sticky: MAX_RETRY consecutive attempts failed
//   retry_cnt      out  CNT_W  consecutive failed attempts, saturating
//   loss_cnt       out  CNT_W  lock losses while in RUN, saturating
//   state_o        out  2      current state encoding (debug)
// BEHAVIOUR
//   Reset values: state RESET, pll_rst=1, rst_out=1, locked_stable=0, fail=0, retry_cnt=0, loss_cnt=0, timer=0.
//   pll_lock passes through a 2-FF synchronizer -> lock_s (2-cycle latency). All outputs are registered.
//   One timer, width $clog2(max(RST_CYCLES,LOCK_TIMEOUT,STABLE_CYCLES)), cleared on every state change.
//   States:
//     RESET     : pll_rst=1, rst_out=1. After exactly RST_CYCLES cycles -> WAIT_LOCK (pll_rst=0 from next cycle).
//     WAIT_LOCK : lock_s=1 -> STABLE. timer==LOCK_TIMEOUT-1 with lock_s=0 -> retry_cnt+1 (sat), -> RESET.
//     STABLE    : lock_s=0 -> WAIT_LOCK (timer restarts, not counted as loss; total timeout not extended by bounce-free rule).
//                 timer==STABLE_CYCLES-1 with lock_s=1 -> RUN; retry_cnt cleared on entry.
//     RUN       : rst_out=0, locked_stable=1 (registered, first low/high cycle = first RUN cycle).
//                 lock_s=0 -> loss_cnt+1 (sat), -> RESET; rst_out=1, locked_stable=0 in the very next cycle.
//   relock_req in WAIT_LOCK/STABLE/RUN -> RESET next cycle; highest priority. Ignored in RESET (timer not restarted).
//   relock_req coincident with lock loss in RUN: both apply (loss_cnt increments, -> RESET).
//   fail set the cycle retry_cnt reaches MAX_RETRY; cleared only by rst. Sequencer keeps retrying while fail=1.
//   Counters saturate at 2^CNT_W-1, never wrap. rst asserted mid-operation: all state returns to reset values immediately.
//   rst_out never deasserts outside RUN; pll_rst is high only in RESET.
// STRUCTURE
//   Shared package pll_seq_pkg: state encoding localparams (RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3), state width.
//   Sub-module sync_2ff (1-bit, async-reset to 0) for pll_lock; FSM, timer and counters in this module.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3, CNT_W=8)
//   Bring-up: pll_lock rises 5 cycles after pll_rst falls and stays -> pll_rst high 4 cycles; rst_out falls 2+1+8 cycles after lock rise; retry_cnt=0.
//   Timeout: pll_lock held 0 -> pll_rst re-pulses every 4+20 cycles; retry_cnt 1,2,3; fail=1 after 3rd timeout and stays.
//   Glitch in STABLE: lock low 3 cycles at STABLE timer=5 -> back to WAIT_LOCK, rst_out stays 1, loss_cnt=0, RUN reached 8 cycles after re-lock.
//   Loss in RUN: drop pll_lock -> rst_out=1 within 3 cycles, loss_cnt=1, pll_rst pulses 4 cycles, relock completes normally.
//   relock_req in RUN and coincident with lock loss -> RESET next cycle; loss_cnt increments only in coincident case; relock_req in RESET ignored.
//   Async rst mid-STABLE and 300 forced losses -> all outputs to reset values without clk; loss_cnt saturates at 255.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and elaboration helpers for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives PLL reset, qualifies LOCK and holds the downstream reset tree until lock
// has been stable; retries on timeout, lock loss or explicit relock request.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             rst_out,
  output logic             locked_stable,
  output logic             fail,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [1:0]       state_o
);

  localparam int TIMER_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_t         state;
  seq_state_t         state_d;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_d;
  logic [CNT_W-1:0]   retry_d;
  logic [CNT_W-1:0]   loss_d;
  logic               fail_d;
  logic               pll_rst_d;
  logic               rst_out_d;
  logic               locked_d;
  logic               lock_s;
  logic               rst_done;
  logic               lock_timeout;
  logic               stable_done;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign rst_done     = (timer == TIMER_W'(RST_CYCLES - 1));
  assign lock_timeout = (timer == TIMER_W'(LOCK_TIMEOUT - 1));
  assign stable_done  = (timer == TIMER_W'(STABLE_CYCLES - 1));
  assign state_o      = state;

  // All outputs come from registers loaded with the values implied by the next state,
  // so they change in the same cycle the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RESET;
      timer         <= '0;
      retry_cnt     <= '0;
      loss_cnt      <= '0;
      fail          <= 1'b0;
      pll_rst       <= 1'b1;
      rst_out       <= 1'b1;
      locked_stable <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      retry_cnt     <= retry_d;
      loss_cnt      <= loss_d;
      fail          <= fail_d;
      pll_rst       <= pll_rst_d;
      rst_out       <= rst_out_d;
      locked_stable <= locked_d;
    end
  end

  // Relock requests win over everything except the fixed-length PLL reset pulse.
  always_comb begin
    state_d = state;
    case (state)
      RESET: begin
        if (rst_done) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (relock_req)        state_d = RESET;
        else if (lock_s)       state_d = STABLE;
        else if (lock_timeout) state_d = RESET;
      end
      STABLE: begin
        if (relock_req)       state_d = RESET;
        else if (!lock_s)     state_d = WAIT_LOCK;
        else if (stable_done) state_d = RUN;
      end
      RUN: begin
        if (relock_req || !lock_s) state_d = RESET;
      end
      default: state_d = RESET;
    endcase
  end

  // A loss in RUN is counted even when a relock request arrives in the same cycle.
  always_comb begin
    timer_d = (state_d != state) ? '0 : timer + 1'b1;

    retry_d = retry_cnt;
    if (state == WAIT_LOCK && !relock_req && !lock_s && lock_timeout)
      retry_d = (retry_cnt == CNT_MAX) ? retry_cnt : retry_cnt + 1'b1;
    else if (state == STABLE && state_d == RUN)
      retry_d = '0;

    loss_d = loss_cnt;
    if (state == RUN && !lock_s)
      loss_d = (loss_cnt == CNT_MAX) ? loss_cnt : loss_cnt + 1'b1;

    fail_d    = fail | (retry_d >= CNT_W'(MAX_RETRY));
    pll_rst_d = (state_d == RESET);
    rst_out_d = (state_d != RUN);
    locked_d  = (state_d == RUN);
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: the driver steps a phase-level model and
// queues expected outputs, an independent monitor compares them after every edge.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 3;
  localparam int CNT_W         = 8;
  localparam int CNT_SAT       = (1 << CNT_W) - 1;

  localparam int PH_RESET  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  typedef struct packed {
    logic             pll_rst;
    logic             rst_out;
    logic             locked_stable;
    logic             fail;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;
    logic [1:0]       state;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             pll_lock;
  logic             relock_req;
  logic             pll_rst;
  logic             rst_out;
  logic             locked_stable;
  logic             fail;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;
  logic [1:0]       state_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Phase-level reference: which phase we are in, how long we've been there,
  // what the synchronizer currently shows and the bookkeeping counters.
  int   m_phase;
  int   m_elapsed;
  int   m_retries;
  int   m_losses;
  bit   m_fail;
  bit   m_s1;
  bit   m_s2;
  logic lock_lvl;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .CNT_W         (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .rst_out       (rst_out),
    .locked_stable (locked_stable),
    .fail          (fail),
    .retry_cnt     (retry_cnt),
    .loss_cnt      (loss_cnt),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("pll_rst", pll_rst, e.pll_rst);
    checkValue("rst_out", rst_out, e.rst_out);
    checkValue("locked_stable", locked_stable, e.locked_stable);
    checkValue("fail", fail, e.fail);
    checkValue("retry_cnt", retry_cnt, e.retry_cnt);
    checkValue("loss_cnt", loss_cnt, e.loss_cnt);
    checkValue("state_o", state_o, e.state);
  endtask

  task automatic model_reset();
    m_phase   = PH_RESET;
    m_elapsed = 0;
    m_retries = 0;
    m_losses  = 0;
    m_fail    = 0;
    m_s1      = 0;
    m_s2      = 0;
  endtask

  task automatic model_step(input logic rv, input logic lk, input logic rq);
    int nxt;
    bit seen;
    if (rv) begin
      model_reset();
      return;
    end
    seen = m_s2;
    nxt  = m_phase;
    if (m_phase == PH_RESET) begin
      if (m_elapsed == RST_CYCLES - 1) nxt = PH_WAIT;
    end else if (rq) begin
      nxt = PH_RESET;
      if (m_phase == PH_RUN && !seen && m_losses < CNT_SAT) m_losses++;
    end else if (m_phase == PH_WAIT) begin
      if (seen) nxt = PH_STABLE;
      else if (m_elapsed == LOCK_TIMEOUT - 1) begin
        nxt = PH_RESET;
        if (m_retries < CNT_SAT) m_retries++;
      end
    end else if (m_phase == PH_STABLE) begin
      if (!seen) nxt = PH_WAIT;
      else if (m_elapsed == STABLE_CYCLES - 1) begin
        nxt = PH_RUN;
        m_retries = 0;
      end
    end else if (!seen) begin
      nxt = PH_RESET;
      if (m_losses < CNT_SAT) m_losses++;
    end
    if (m_retries >= MAX_RETRY) m_fail = 1;
    m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
    m_phase   = nxt;
    m_s2      = m_s1;
    m_s1      = lk;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.pll_rst       = (m_phase == PH_RESET);
    e.rst_out       = (m_phase != PH_RUN);
    e.locked_stable = (m_phase == PH_RUN);
    e.fail          = m_fail;
    e.retry_cnt     = CNT_W'(m_retries);
    e.loss_cnt      = CNT_W'(m_losses);
    e.state         = 2'(m_phase);
    return e;
  endfunction

  task automatic applyStimulus(input logic lk, input logic rq, input logic rv);
    rst        = rv;
    pll_lock   = lk;
    relock_req = rq;
    model_step(rv, lk, rq);
    exp_q.push_back(model_expect());
  endtask

  task automatic tick(input logic lk, input logic rq);
    @(negedge clk);
    applyStimulus(lk, rq, 1'b0);
  endtask

  task automatic run_until(input int target, input logic lk, input int bound, input string name);
    int i;
    i = 0;
    while (m_phase != target && i < bound) begin
      tick(lk, 1'b0);
      i++;
    end
    if (m_phase != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: phase %0d after %0d cycles, expected %0d", name, m_phase, i, target);
    end
  endtask

  task automatic async_reset_check(input logic lk);
    exp_t r;
    r = '{pll_rst: 1'b1, rst_out: 1'b1, locked_stable: 1'b0, fail: 1'b0,
          retry_cnt: '0, loss_cnt: '0, state: 2'd0};
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput(r);
    applyStimulus(lk, 1'b0, 1'b1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int  n;
    int  i;
    bit  seen;
    logic rq;
    rst = 1'b1;
    pll_lock = 1'b0;
    relock_req = 1'b0;
    lock_lvl = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end

    $display("[TB] bring-up");
    run_until(PH_WAIT, 1'b0, 20, "bringup_wait");
    repeat (4) tick(1'b0, 1'b0);
    n = 0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick(1'b1, 1'b0);
      n++;
      after_edge();
      if (rst_out === 1'b0) seen = 1;
    end
    checkValue("bringup_latency", n, 2 + 1 + STABLE_CYCLES);

    $display("[TB] loss in RUN");
    repeat (3) tick(1'b1, 1'b0);
    run_until(PH_RESET, 1'b0, 10, "loss_to_reset");
    repeat ($urandom_range(0, 8)) tick(1'b0, 1'b0);
    run_until(PH_RUN, 1'b1, 100, "loss_relock");

    $display("[TB] lock timeout");
    repeat (2) tick(1'b1, 1'b0);
    run_until(PH_RESET, 1'b0, 10, "timeout_drop");
    repeat (3 * (RST_CYCLES + LOCK_TIMEOUT) + 12) tick(1'b0, 1'b0);
    after_edge();
    checkValue("retry_after_timeouts", retry_cnt, MAX_RETRY);
    checkValue("fail_after_timeouts", fail, 1);
    repeat (30) tick(1'b0, 1'b0);
    after_edge();
    checkValue("fail_sticky", fail, 1);

    $display("[TB] async reset mid-STABLE");
    run_until(PH_STABLE, 1'b1, 100, "timeout_recover");
    repeat ($urandom_range(0, 6)) tick(1'b1, 1'b0);
    async_reset_check(1'b1);

    $display("[TB] glitch in STABLE");
    run_until(PH_STABLE, 1'b1, 100, "glitch_stable");
    i = 0;
    while (!(m_phase == PH_STABLE && m_elapsed == 5) && i < 20) begin
      tick(1'b1, 1'b0);
      i++;
    end
    repeat (3) tick(1'b0, 1'b0);
    run_until(PH_RUN, 1'b1, 100, "glitch_run");
    after_edge();
    checkValue("glitch_loss", loss_cnt, 0);

    $display("[TB] relock requests");
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    after_edge();
    checkValue("relock_run_state", state_o, PH_RESET);
    checkValue("relock_run_loss", loss_cnt, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    run_until(PH_RUN, 1'b1, 100, "relock_rerun");
    i = 0;
    while (!(m_phase == PH_RUN && m_s2 == 0) && i < 10) begin
      tick(1'b0, 1'b0);
      i++;
    end
    tick(1'b0, 1'b1);
    after_edge();
    checkValue("coincident_state", state_o, PH_RESET);
    checkValue("coincident_loss", loss_cnt, 1);
    run_until(PH_WAIT, 1'b0, 20, "relock_wait");
    tick(1'b0, 1'b1);
    run_until(PH_STABLE, 1'b1, 100, "relock_stable");
    tick(1'b1, 1'b1);
    run_until(PH_RUN, 1'b1, 100, "relock_final");

    $display("[TB] random traffic");
    lock_lvl = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (lock_lvl ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0))
        lock_lvl = ~lock_lvl;
      rq = ($urandom_range(0, 39) == 0);
      tick(lock_lvl, rq);
    end

    $display("[TB] loss counter saturation");
    for (int k = 0; k < 300; k++) begin
      run_until(PH_RUN, 1'b1, 200, "sat_run");
      repeat ($urandom_range(0, 3)) tick(1'b1, 1'b0);
      run_until(PH_RESET, 1'b0, 10, "sat_drop");
    end
    run_until(PH_RUN, 1'b1, 200, "sat_final");
    after_edge();
    checkValue("loss_saturated", loss_cnt, CNT_SAT);
    async_reset_check(1'b1);
    repeat (5) tick(1'b1, 1'b0);

    after_edge();
    #1;
    checkValue("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
